// File: rtl/sig_collector.sv
// Signature collector: discards WARMUP leading beats, folds the rest of a
// TOTAL-beat run into a 64-bit LFSR-style signature and compares it to a golden value.
module sig_collector #(
    parameter int unsigned WARMUP = 10,
    parameter int unsigned TOTAL  = 90
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        in_valid,
    input  logic [31:0] in_data,
    input  logic [63:0] expected,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic        fail,
    output logic [63:0] sig,
    output logic [15:0] beat_cnt
);

    localparam int unsigned CNT_W  = 16;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned SIG_W  = 64;

    // Count values of the last warmup beat and the last beat of the run.
    // WARM_LAST wraps when WARMUP=0, which is harmless: WARM is never entered then.
    localparam logic [CNT_W-1:0] WARM_LAST  = CNT_W'(WARMUP - 1);
    localparam logic [CNT_W-1:0] TOTAL_LAST = CNT_W'(TOTAL - 1);

    if (TOTAL == 0 || WARMUP >= TOTAL || TOTAL > 65535) begin : g_param_check
        $error("sig_collector: illegal parameters WARMUP=%0d TOTAL=%0d", WARMUP, TOTAL);
    end

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WARM,
        ST_ACC,
        ST_DONE
    } state_t;

    state_t             state_q;
    logic [SIG_W-1:0]   sig_q;
    logic [SIG_W-1:0]   sig_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   cnt_d;
    logic               busy_q;
    logic               done_q;
    logic               pass_q;
    logic               fail_q;

    // Next signature: shift with feedback taps 63/2/0, then xor in the beat.
    always_comb begin
        sig_d = {{(SIG_W - DATA_W){1'b0}}, in_data}
              ^ {sig_q[SIG_W-2:0], sig_q[SIG_W-1] ^ sig_q[2] ^ sig_q[0]};
        cnt_d = cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            sig_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            fail_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        sig_q   <= '0;
                        cnt_q   <= '0;
                        pass_q  <= 1'b0;
                        fail_q  <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= (WARMUP == 0) ? ST_ACC : ST_WARM;
                    end
                end
                ST_WARM: begin
                    if (in_valid) begin
                        cnt_q <= cnt_d;
                        if (cnt_q == WARM_LAST) begin
                            state_q <= ST_ACC;
                        end
                    end
                end
                ST_ACC: begin
                    if (in_valid) begin
                        cnt_q <= cnt_d;
                        sig_q <= sig_d;
                        if (cnt_q == TOTAL_LAST) begin
                            state_q <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    done_q  <= 1'b1;
                    pass_q  <= (sig_q == expected);
                    fail_q  <= (sig_q != expected);
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign pass     = pass_q;
    assign fail     = fail_q;
    assign sig      = sig_q;
    assign beat_cnt = cnt_q;

endmodule

// File: tb/tb_sig_collector.sv
// Bench for sig_collector: three parameterisations driven by directed runs,
// checked every cycle against a beat-counting run model plus literal expectations.
module tb_sig_collector;

    localparam int NDUT = 3;
    int W_A[NDUT] = '{0, 2, 10};
    int T_A[NDUT] = '{2, 3, 90};

    logic        clk = 1'b0;
    logic        rst_a      [NDUT];
    logic        start_a    [NDUT];
    logic        in_valid_a [NDUT];
    logic [31:0] in_data_a  [NDUT];
    logic [63:0] exp_a      [NDUT];
    logic        busy_a     [NDUT];
    logic        done_a     [NDUT];
    logic        pass_a     [NDUT];
    logic        fail_a     [NDUT];
    logic [63:0] sig_a      [NDUT];
    logic [15:0] cnt_a      [NDUT];

    sig_collector #(.WARMUP(0), .TOTAL(2)) u_dut0 (
        .clk(clk), .rst(rst_a[0]), .start(start_a[0]), .in_valid(in_valid_a[0]),
        .in_data(in_data_a[0]), .expected(exp_a[0]), .busy(busy_a[0]), .done(done_a[0]),
        .pass(pass_a[0]), .fail(fail_a[0]), .sig(sig_a[0]), .beat_cnt(cnt_a[0]));

    sig_collector #(.WARMUP(2), .TOTAL(3)) u_dut1 (
        .clk(clk), .rst(rst_a[1]), .start(start_a[1]), .in_valid(in_valid_a[1]),
        .in_data(in_data_a[1]), .expected(exp_a[1]), .busy(busy_a[1]), .done(done_a[1]),
        .pass(pass_a[1]), .fail(fail_a[1]), .sig(sig_a[1]), .beat_cnt(cnt_a[1]));

    sig_collector u_dut2 (
        .clk(clk), .rst(rst_a[2]), .start(start_a[2]), .in_valid(in_valid_a[2]),
        .in_data(in_data_a[2]), .expected(exp_a[2]), .busy(busy_a[2]), .done(done_a[2]),
        .pass(pass_a[2]), .fail(fail_a[2]), .sig(sig_a[2]), .beat_cnt(cnt_a[2]));

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    bit chk_en = 1'b0;

    // Run model: a run is "open" from an accepted start until TOTAL beats are
    // taken; the result is published one edge later.
    bit          m_open [NDUT];
    bit          m_fin  [NDUT];
    int          m_cnt  [NDUT];
    logic [63:0] m_sig  [NDUT];
    bit          m_done [NDUT];
    bit          m_pass [NDUT];
    bit          m_fail [NDUT];
    int          done_cnt [NDUT];
    int          done_cyc [NDUT];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input int k, input logic [63:0] act,
                         input logic [63:0] want);
        n_vec++;
        if (act !== want) begin
            n_err++;
            $display("FAIL %s dut%0d @cyc %0d: got %h, want %h", nm, k, cyc, act, want);
        end
    endtask

    function automatic logic [63:0] fold(input logic [63:0] s, input logic [31:0] d);
        return {32'h0, d} ^ {s[62:0], s[63] ^ s[2] ^ s[0]};
    endfunction

    // Inputs only change just after posedge, so at negedge they are exactly what
    // the next posedge samples: compare first, then advance the model.
    always @(negedge clk) begin
        for (int k = 0; k < NDUT; k++) begin
            if (chk_en) begin
                check("busy", k, 64'(busy_a[k]), 64'(m_open[k] | m_fin[k]));
                check("done", k, 64'(done_a[k]), 64'(m_done[k]));
                check("pass", k, 64'(pass_a[k]), 64'(m_pass[k]));
                check("fail", k, 64'(fail_a[k]), 64'(m_fail[k]));
                check("sig",  k, sig_a[k], m_sig[k]);
                check("beat_cnt", k, 64'(cnt_a[k]), 64'(m_cnt[k]));
            end
            if (done_a[k] === 1'b1) begin
                done_cnt[k]++;
                done_cyc[k] = cyc;
            end
            m_done[k] = 1'b0;
            if (rst_a[k]) begin
                m_open[k] = 1'b0; m_fin[k] = 1'b0; m_cnt[k] = 0; m_sig[k] = '0;
                m_pass[k] = 1'b0; m_fail[k] = 1'b0;
            end else if (m_fin[k]) begin
                m_fin[k]  = 1'b0;
                m_done[k] = 1'b1;
                m_pass[k] = (m_sig[k] == exp_a[k]);
                m_fail[k] = !m_pass[k];
            end else if (!m_open[k]) begin
                if (start_a[k]) begin
                    m_open[k] = 1'b1; m_cnt[k] = 0; m_sig[k] = '0;
                    m_pass[k] = 1'b0; m_fail[k] = 1'b0;
                end
            end else if (in_valid_a[k]) begin
                if (m_cnt[k] >= W_A[k]) m_sig[k] = fold(m_sig[k], in_data_a[k]);
                m_cnt[k]++;
                if (m_cnt[k] == T_A[k]) begin
                    m_open[k] = 1'b0;
                    m_fin[k]  = 1'b1;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_run(input int k);
        start_a[k] = 1'b1;
        tick();
        start_a[k] = 1'b0;
    endtask

    task automatic beat(input int k, input logic [31:0] d);
        in_valid_a[k] = 1'b1;
        in_data_a[k]  = d;
        tick();
        in_valid_a[k] = 1'b0;
        in_data_a[k]  = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        int d2;
        int last_cyc;
        for (int k = 0; k < NDUT; k++) begin
            rst_a[k] = 1'b1; start_a[k] = 1'b1; in_valid_a[k] = 1'b1;
            in_data_a[k] = 32'hFFFF_FFFF; exp_a[k] = '0;
            done_cnt[k] = 0; done_cyc[k] = -1;
            m_open[k] = 1'b0; m_fin[k] = 1'b0; m_cnt[k] = 0; m_sig[k] = '0;
            m_done[k] = 1'b0; m_pass[k] = 1'b0; m_fail[k] = 1'b0;
        end
        // Reset overrides start/in_valid held high alongside it.
        tick();
        tick();
        for (int k = 0; k < NDUT; k++) begin
            check("rst_busy", k, 64'(busy_a[k]), 64'd0);
            check("rst_sig", k, sig_a[k], 64'd0);
            check("rst_cnt", k, 64'(cnt_a[k]), 64'd0);
            check("rst_flags", k, {61'd0, done_a[k], pass_a[k], fail_a[k]}, 64'd0);
            rst_a[k] = 1'b0; start_a[k] = 1'b0; in_valid_a[k] = 1'b0; in_data_a[k] = '0;
        end
        chk_en = 1'b1;

        // WARMUP=0 run, matching golden; beats in IDLE and DONE are ignored.
        exp_a[0] = 64'h14A;
        beat(0, 32'hDEAD_BEEF);
        check("idle_beat_cnt", 0, 64'(cnt_a[0]), 64'd0);
        start_run(0);
        check("start_busy", 0, 64'(busy_a[0]), 64'd1);
        beat(0, 32'h0000_00A5);
        check("sig_first", 0, sig_a[0], 64'hA5);
        beat(0, 32'h0000_0000);
        check("sig_final", 0, sig_a[0], 64'h14A);
        check("done_early", 0, 64'(done_a[0]), 64'd0);
        beat(0, 32'hFFFF_FFFF);
        check("done_pulse", 0, 64'(done_a[0]), 64'd1);
        check("pass_set", 0, {62'd0, pass_a[0], fail_a[0]}, 64'b10);
        check("cnt_final", 0, 64'(cnt_a[0]), 64'd2);
        tick();
        check("done_drop", 0, 64'(done_a[0]), 64'd0);

        // Same stimulus against a wrong golden: fail sticks.
        exp_a[0] = 64'h0;
        start_run(0);
        beat(0, 32'h0000_00A5);
        beat(0, 32'h0000_0000);
        tick();
        check("fail_set", 0, {61'd0, done_a[0], pass_a[0], fail_a[0]}, 64'b101);
        repeat (5) tick();
        check("fail_hold", 0, {62'd0, pass_a[0], fail_a[0]}, 64'b01);
        check("sig_hold", 0, sig_a[0], 64'h14A);

        // Idle gaps and a second start mid-run.
        exp_a[0] = 64'h14A;
        d0 = done_cnt[0];
        start_run(0);
        beat(0, 32'h0000_00A5);
        tick();
        start_run(0);
        tick();
        beat(0, 32'h0000_0000);
        repeat (3) tick();
        check("done_once", 0, 64'(done_cnt[0]), 64'(d0 + 1));
        check("gap_sig", 0, sig_a[0], 64'h14A);
        check("gap_pass", 0, 64'(pass_a[0]), 64'd1);

        // Start coincident with the done pulse.
        start_run(0);
        beat(0, 32'h0000_00A5);
        beat(0, 32'h0000_0000);
        tick();
        check("done_cycle", 0, 64'(done_a[0]), 64'd1);
        start_run(0);
        check("restart_state", 0, {60'd0, busy_a[0], done_a[0], pass_a[0], fail_a[0]}, 64'b1000);
        beat(0, 32'h0000_00A5);
        beat(0, 32'h0000_0000);
        repeat (2) tick();

        // WARMUP=2, TOTAL=3: warm beats leave sig at zero.
        exp_a[1] = 64'h7;
        start_run(1);
        beat(1, 32'hFFFF_FFFF);
        check("warm_sig1", 1, sig_a[1], 64'd0);
        beat(1, 32'hFFFF_FFFF);
        check("warm_sig2", 1, sig_a[1], 64'd0);
        check("warm_cnt2", 1, 64'(cnt_a[1]), 64'd2);
        beat(1, 32'h0000_0007);
        tick();
        check("w_done", 1, 64'(done_a[1]), 64'd1);
        check("w_sig", 1, sig_a[1], 64'h7);
        check("w_cnt", 1, 64'(cnt_a[1]), 64'd3);
        check("w_pass", 1, 64'(pass_a[1]), 64'd1);

        // Defaults: abort after 40 beats, then a full 90-beat run with gaps.
        start_run(2);
        for (int i = 0; i < 40; i++) beat(2, 32'(i) * 32'h0101_0101 + 32'h5);
        d2 = done_cnt[2];
        rst_a[2] = 1'b1; start_a[2] = 1'b1; in_valid_a[2] = 1'b1;
        tick();
        rst_a[2] = 1'b0; start_a[2] = 1'b0; in_valid_a[2] = 1'b0;
        check("abort_cnt", 2, 64'(cnt_a[2]), 64'd0);
        check("abort_busy", 2, 64'(busy_a[2]), 64'd0);
        repeat (3) tick();
        check("abort_nodone", 2, 64'(done_cnt[2]), 64'(d2));
        start_run(2);
        for (int i = 0; i < 90; i++) begin
            if (i % 7 == 3) tick();
            beat(2, 32'hA5A5_0000 ^ (32'(i) * 32'h0001_3579));
        end
        last_cyc = cyc;
        exp_a[2] = m_sig[2];
        for (int i = 0; i < 10 && done_cnt[2] == d2; i++) tick();
        check("full_done", 2, 64'(done_cnt[2]), 64'(d2 + 1));
        check("full_latency", 2, 64'(done_cyc[2]), 64'(last_cyc + 1));
        check("full_cnt", 2, 64'(cnt_a[2]), 64'd90);
        check("full_pass", 2, 64'(pass_a[2]), 64'd1);
        repeat (2) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/sig_collector.md
SIG_COLLECTOR -- requirements
Module: sig_collector

Interface
REQ-001 The block SHALL have parameter WARMUP, default 10, giving the number of leading accepted beats discarded before accumulation.
REQ-002 The block SHALL have parameter TOTAL, default 90, giving the total accepted beats per run, warmup included; legal range WARMUP < TOTAL <= 65535.
REQ-003 clk  input  1  the single clock; all state updates on posedge clk.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 start  input  1  single-cycle request to begin a run.
REQ-006 in_valid  input  1  qualifies in_data as one beat of the upstream result stream.
REQ-007 in_data  input  32  result beat from the upstream device under test.
REQ-008 expected  input  64  golden signature, sampled in DONE.
REQ-009 busy  output  1  high in WARM, ACC and DONE.
REQ-010 done  output  1  one-cycle pulse marking the end of a run.
REQ-011 pass  output  1  sticky; final signature equals expected.
REQ-012 fail  output  1  sticky; final signature differs from expected.
REQ-013 sig  output  64  current signature register.
REQ-014 beat_cnt  output  16  accepted beats in the current run.

Function
REQ-015 The state machine SHALL have the states IDLE, WARM, ACC and DONE, with all outputs registered.
REQ-016 In IDLE, start SHALL clear sig, beat_cnt, pass and fail, and enter WARM, or enter ACC directly when WARMUP=0.
REQ-017 start SHALL be ignored in WARM, ACC and DONE.
REQ-018 A beat SHALL be accepted only in WARM or ACC with in_valid=1; in_valid in IDLE or DONE SHALL be ignored.
REQ-019 Each accepted beat SHALL increment beat_cnt by 1, and a cycle with in_valid=0 SHALL hold all state.
REQ-020 In WARM, sig SHALL be held at 0, and the beat accepted with beat_cnt==WARMUP-1 SHALL move the state to ACC.
REQ-021 In ACC, each accepted beat SHALL update sig <= {32'h0,in_data} ^ {sig[62:0], sig[63]^sig[2]^sig[0]}, using modulo-2^64 width and no other masking.
REQ-022 The ACC beat accepted with beat_cnt==TOTAL-1 SHALL update sig and then enter DONE.
REQ-023 On the edge leaving DONE, the block SHALL set done<=1, pass<=(sig==expected), fail<=(sig!=expected), and state<=IDLE.
REQ-024 Latency: done SHALL be high during the second cycle after the edge that accepts the last beat, for exactly one cycle.
REQ-025 pass and fail SHALL be mutually exclusive and SHALL hold until the next accepted start or rst.
REQ-026 sig and beat_cnt SHALL hold their final values in IDLE until the next start.
REQ-027 start coincident with the done pulse is in IDLE and SHALL be accepted: pass and fail clear on that edge, while done still drops after its one cycle.
REQ-028 beat_cnt SHALL never wrap, because TOTAL <= 65535.
REQ-029 Illegal parameters (WARMUP >= TOTAL or TOTAL = 0) SHALL be flagged by an elaboration-time $error.

Reset
REQ-030 On rst=1 at a clock edge, the block SHALL set state=IDLE, sig=0, beat_cnt=0, busy=0, done=0, pass=0 and fail=0, overriding start and in_valid in the same cycle.
REQ-031 rst mid-run SHALL abort the run without asserting done, and a later start SHALL behave exactly as after power-up.

Verification
REQ-032 WARMUP=0, TOTAL=2, beats 32'h000000A5 then 32'h00000000, expected=64'h14A -> sig=64'h14A, and one-cycle done with pass=1, fail=0.
REQ-033 Same stimulus with expected=64'h0 -> done=1, pass=0, fail=1, and both flags hold through 5 further idle cycles.
REQ-034 WARMUP=2, TOTAL=3, beats 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000007 -> sig stays 0 during WARM, and final sig=64'h7 with beat_cnt=3.
REQ-035 The REQ-032 stimulus with 3 idle in_valid=0 cycles between beats and a second start pulse mid-run -> identical sig=64'h14A, done exactly once, and the second start ignored.
REQ-036 Defaults, rst asserted after 40 accepted beats, then a restart with 90 beats -> no done during the abort, beat_cnt=0 after reset, and the restarted run completes with done 2 edges after beat 90.
REQ-037 start asserted in the done cycle -> busy=1 next cycle, pass=fail=0, and done low after one cycle.
